// File: rtl/pclk_en_gen.sv
// APB clock-enable generator: modulo-N phase counter with a glitch-free req/ack ratio change.
// Define PCLK_EN_GEN_CLKOUT_EN to add the registered divided clock output clk_out.
module pclk_en_gen #(
    parameter int CNT_W       = 4,
    parameter int DEFAULT_DIV = 5
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             div_req,
    input  logic [CNT_W-1:0] div_val,
    output logic             div_ack,
    output logic [CNT_W-1:0] div_cur,
    output logic [CNT_W-1:0] cnt,
    output logic             pclk_en
`ifdef PCLK_EN_GEN_CLKOUT_EN
    ,
    output logic             clk_out
`endif
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] div_cur_reg, div_next;
    logic             div_ack_reg, div_ack_next;
    logic             pclk_en_reg, pclk_en_next;
    logic             last_phase;
    logic             accept;

    // A request is only taken on a period boundary (or while idle), and never in
    // the ack cycle itself, so a requester dropping div_req on seeing ack is not
    // counted twice.
    always_comb begin
        last_phase   = (cnt_reg == div_cur_reg - ONE);
        accept       = div_req && !div_ack_reg && (!en || last_phase);
        div_next     = div_cur_reg;
        cnt_next     = cnt_reg;
        div_ack_next = 1'b0;
        if (accept) begin
            div_next     = (div_val == '0) ? ONE : div_val;
            cnt_next     = '0;
            div_ack_next = 1'b1;
        end else if (en) begin
            cnt_next = last_phase ? '0 : cnt_reg + ONE;
        end else begin
            cnt_next = '0;
        end
        // Strobe is registered alongside cnt so it coincides with cnt == N-1.
        pclk_en_next = en && (cnt_next == div_next - ONE);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg     <= '0;
            div_cur_reg <= DIV_RST;
            div_ack_reg <= 1'b0;
            pclk_en_reg <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            div_cur_reg <= div_next;
            div_ack_reg <= div_ack_next;
            pclk_en_reg <= pclk_en_next;
        end
    end

    assign cnt     = cnt_reg;
    assign div_cur = div_cur_reg;
    assign div_ack = div_ack_reg;
    assign pclk_en = pclk_en_reg;

`ifdef PCLK_EN_GEN_CLKOUT_EN
    logic [CNT_W:0] high_len;
    logic           clk_out_reg, clk_out_next;

    // One extra bit so (N+1)/2 cannot overflow at the largest N.
    always_comb begin
        high_len     = ({1'b0, div_next} + (CNT_W+1)'(1)) >> 1;
        clk_out_next = en && ({1'b0, cnt_next} < high_len);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            clk_out_reg <= 1'b0;
        end else begin
            clk_out_reg <= clk_out_next;
        end
    end

    assign clk_out = clk_out_reg;
`endif

endmodule

// File: tb/tb_pclk_en_gen.sv
// Directed bench for pclk_en_gen: expected strobe/ack events go into a scoreboard queue
// that a negedge monitor pops and compares against the cycle, event kind and div_cur.
module tb_pclk_en_gen;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       en;
    logic       div_req;
    logic [3:0] div_val;
    logic       div_ack;
    logic [3:0] div_cur;
    logic [3:0] cnt;
    logic       pclk_en;
`ifdef PCLK_EN_GEN_CLKOUT_EN
    logic       clk_out;
`endif

    pclk_en_gen #(.CNT_W(4), .DEFAULT_DIV(5)) dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .en      (en),
        .div_req (div_req),
        .div_val (div_val),
        .div_ack (div_ack),
        .div_cur (div_cur),
        .cnt     (cnt),
        .pclk_en (pclk_en)
`ifdef PCLK_EN_GEN_CLKOUT_EN
        ,
        .clk_out (clk_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit is_ack;
        int cur;
    } ev_t;

    ev_t sb_q[$];
    int  base    = 0;
    bit  started = 1'b0;
    int  n_total = 0;
    int  n_pass  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc - base, act, exp);
    endtask

    task automatic push_ev(input int off, input bit is_ack, input int cur);
        ev_t e;
        e.cyc = base + off;
        e.is_ack = is_ack;
        e.cur = cur;
        sb_q.push_back(e);
    endtask

    task automatic at(input int off);
        while (cyc < base + off) @(negedge clk_in);
    endtask

    task automatic match(input bit is_ack);
        ev_t e;
        n_total++;
        if (sb_q.size() == 0) begin
            $display("FAIL unexpected_%s @cyc %0d: div_cur=%0d, no event expected",
                     is_ack ? "ack" : "pclk", cyc - base, div_cur);
        end else begin
            e = sb_q.pop_front();
            if (e.cyc == cyc && e.is_ack == is_ack && e.cur == int'(div_cur)) begin
                n_pass++;
            end else begin
                $display("FAIL event_%s: got cyc %0d div_cur %0d, expected %s at cyc %0d div_cur %0d",
                         is_ack ? "ack" : "pclk", cyc - base, div_cur,
                         e.is_ack ? "ack" : "pclk", e.cyc - base, e.cur);
            end
        end
    endtask

    // Monitor: flags expected events that never showed, then consumes observed ones.
    always @(negedge clk_in) begin
        if (started) begin
            while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                n_total++;
                $display("FAIL missed_event: expected %s at cyc %0d, now cyc %0d",
                         sb_q[0].is_ack ? "ack" : "pclk", sb_q[0].cyc - base, cyc - base);
                void'(sb_q.pop_front());
            end
            if (rst_n === 1'b1 && div_ack === 1'b1) match(1'b1);
            if (rst_n === 1'b1 && pclk_en === 1'b1) match(1'b0);
        end
    end

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        div_req = 1'b0;
        div_val = 4'd0;
        repeat (3) @(negedge clk_in);
        check("rst_cnt", int'(cnt), 0);
        check("rst_div_cur", int'(div_cur), 5);
        check("rst_pclk_en", int'(pclk_en), 0);
        check("rst_div_ack", int'(div_ack), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_in);

        base = cyc;
        // N=5 free-running, then 5->3 at a boundary, N=1 via clamped 0, back to 5,
        // cancelled request, reset abort, finally N=4.
        push_ev(4, 0, 5);  push_ev(9, 0, 5);  push_ev(14, 0, 5); push_ev(19, 0, 5);
        push_ev(20, 1, 3);
        push_ev(22, 0, 3); push_ev(25, 0, 3); push_ev(28, 0, 3);
        push_ev(31, 1, 1);
        for (int k = 34; k <= 38; k++) push_ev(k, 0, 1);
        push_ev(41, 1, 5);
        push_ev(47, 0, 5); push_ev(52, 0, 5); push_ev(57, 0, 5);
        push_ev(71, 1, 4);
        push_ev(75, 0, 4); push_ev(79, 0, 4);
        started = 1'b1;
        en = 1'b1;

`ifdef PCLK_EN_GEN_CLKOUT_EN
        for (int k = 5; k <= 9; k++) begin
            at(k);
            check("clk_out_n5", int'(clk_out), (k <= 7) ? 1 : 0);
        end
`endif
        at(16); div_req = 1'b1; div_val = 4'd3;
        at(20); div_req = 1'b0;
        at(28); en = 1'b0;
        at(30); check("en_low_cnt", int'(cnt), 0);
                div_req = 1'b1; div_val = 4'd0;
        at(31); div_req = 1'b0;
        at(33); en = 1'b1;
        at(38); en = 1'b0;
        at(39); check("n1_pclk_off", int'(pclk_en), 0);
        at(40); div_req = 1'b1; div_val = 4'd5;
        at(41); div_req = 1'b0;
        at(43); en = 1'b1;
        at(48); div_req = 1'b1; div_val = 4'd7;
        at(50); div_req = 1'b0;
        at(58); div_req = 1'b1; div_val = 4'd9;
        at(60); rst_n = 1'b0; div_req = 1'b0; en = 1'b0;
        at(61); check("rst2_cnt", int'(cnt), 0);
                check("rst2_div_cur", int'(div_cur), 5);
                check("rst2_pclk_en", int'(pclk_en), 0);
                check("rst2_div_ack", int'(div_ack), 0);
        at(62); rst_n = 1'b1;
        at(70); check("post_rst_div_cur", int'(div_cur), 5);
                div_req = 1'b1; div_val = 4'd4;
        at(71); div_req = 1'b0;
        at(72); en = 1'b1;
`ifdef PCLK_EN_GEN_CLKOUT_EN
        for (int k = 76; k <= 79; k++) begin
            at(k);
            check("clk_out_n4", int'(clk_out), (k <= 77) ? 1 : 0);
        end
`endif
        at(80); en = 1'b0;
        at(81); check("en_off_cnt", int'(cnt), 0);
`ifdef PCLK_EN_GEN_CLKOUT_EN
                check("en_off_clk_out", int'(clk_out), 0);
`endif
        at(85); check("sb_leftover", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pclk_en_gen.md
# pclk_en_gen

Programmable APB clock-enable generator running on the AHB clock, placed upstream of the APB bridge and peripheral logic that consume the divided clock. It counts `clk_in` cycles modulo a runtime-programmable ratio N and produces a one-cycle `pclk_en` strobe per period. Optionally it also produces a registered divided clock. Ratio changes use a req/ack handshake and take effect only on a period boundary, so the strobe stream never glitches.

## Interface
- `CNT_W`, 4, counter and ratio width; legal N is 1..2^CNT_W-1.
- `DEFAULT_DIV`, 5, ratio loaded at reset; must lie in 1..2^CNT_W-1.
- `clk_in`  in  1  AHB clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  run enable; counting happens only while high.
- `div_req`  in  1  ratio-change request; level, held until `div_ack`.
- `div_val`  in  CNT_W  requested ratio; must be stable while `div_req`=1.
- `div_ack`  out  1  one-cycle pulse; new ratio is now in effect.
- `div_cur`  out  CNT_W  ratio currently in effect.
- `cnt`  out  CNT_W  phase counter, range 0..N-1.
- `pclk_en`  out  1  APB enable strobe.
- `clk_out`  out  1  divided clock; present only with `PCLK_EN_GEN_CLKOUT_EN`.

## Operation
- Reset values: `cnt`=0, `div_cur`=DEFAULT_DIV, `pclk_en`=0, `div_ack`=0, `clk_out`=0. All outputs are registered.
- Counter:
  - When `en`=1: `cnt` increments and wraps from N-1 to 0.
  - When `en`=0: `cnt` is forced to 0 on the next edge, and `pclk_en`=0.
- Strobe: `pclk_en`=1 exactly in the cycles where `cnt`==N-1 and `en`=1.
  - For N=1, `pclk_en` stays 1 continuously while `en`=1.
- Ratio change:
  - The request is accepted at the edge where `div_req`=1 and either (`en`=1 and `cnt`==N-1) or `en`=0.
  - On that edge: `div_cur` loads `div_val`, `cnt` loads 0, and `div_ack`=1 for the following cycle only.
  - The requester deasserts `div_req` in the cycle `div_ack` is seen. A `div_req` still high in the cycle after `div_ack` is a new request.
  - If `div_req` drops before acceptance, the request is cancelled and nothing changes.
- `div_val`=0 is clamped to 1. `div_cur` never holds 0.
- Simultaneous `en` fall and acceptance: the ratio is applied, `cnt`=0, and the counter stays idle.
- Reset mid-operation aborts any pending request. No `div_ack` is issued and `div_cur` returns to DEFAULT_DIV.

## Timing
- Latency from `en` rising (sampled at edge E0): `cnt`=1 after E0. The first `pclk_en` appears N-1 cycles after E0 for N>1, and at E0+1 for N=1. After that the period is exactly N cycles.
- Handshake latency: `div_ack` arrives 1 cycle after acceptance. The worst-case wait from `div_req` rising to acceptance is N_old cycles.
- The first `pclk_en` at the new ratio occurs N_new cycles after the final old-ratio `pclk_en`. There are no short or merged periods.
- `div_cur` and `div_ack` change on the same edge.

## Configuration
- `PCLK_EN_GEN_CLKOUT_EN` defined:
  - `clk_out` is registered high while `cnt` < (N+1)/2 (integer division) and `en`=1, otherwise low.
  - This gives N=4 a 2/2 duty cycle, N=5 a 3/2 duty cycle, and N=1 a constant 1 while enabled.
  - `clk_out` is a posedge-only approximation; 50% duty for odd N is produced downstream.
- `PCLK_EN_GEN_CLKOUT_EN` undefined: the `clk_out` port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, `en`=1, no requests, DEFAULT_DIV=5:
  - `pclk_en` pulses at cycles 4, 9, 14 after enable.
  - `div_cur`=5 and `div_ack` never asserts.
- At N=5, raise `div_req` with `div_val`=3 at `cnt`=1:
  - Accepted on the `cnt`=4 edge; `div_ack` is a single pulse and `div_cur`=3.
  - Successive `pclk_en` pulses are spaced 5 then 3 cycles apart.
- With `en`=0, request `div_val`=0:
  - Accepted on the next edge and `div_cur`=1.
  - After `en`=1, `pclk_en` stays high every cycle.
- Raise `div_req` with `div_val`=7, then drop it after 2 cycles while at N=5 and `cnt`=0:
  - No `div_ack` occurs and `div_cur` stays 5.
- Assert `rst_n`=0 while a request to 9 is pending:
  - All outputs return to reset values, `div_cur`=5, and no `div_ack` is issued after release.
- With `PCLK_EN_GEN_CLKOUT_EN` defined:
  - N=5 gives `clk_out` 3 cycles high, 2 cycles low.
  - N=4 gives 2 high, 2 low.
  - `en`=0 forces `clk_out`=0 on the next edge.
